jtpopeye_mem_arb: RTL and testbench
===================================

// Module: jtpopeye_mem_arb
// PURPOSE
//  Shares one 16-bit ROM memory port (BRAM or SDRAM front-end) between the ioctl ROM download
//  stream and two game read requesters: main CPU and graphics fetch. Packs download bytes
//  into words and sequences writes. Arbitrates reads round-robin and holds per-requester
//  valid flags. Sits between hps_io/ioctl and jtpopeye_game ROM buses.
// PARAMETERS
//  MW       15  memory word-address width
//  CPU_OFS  0   word offset added to cpu_addr
//  GFX_OFS  0   word offset added to gfx_addr
// PORTS
//  clk          in   1   system clock, 40 MHz
//  rst          in   1   asynchronous reset, active high
//  downloading  in   1   ROM download in progress
//  ioctl_addr   in   22  download byte address
//  ioctl_data   in   8   download byte
//  ioctl_wr     in   1   byte strobe, one cycle
//  cpu_req      in   1   CPU read request, level
//  cpu_addr     in   MW  CPU word address
//  cpu_data     out  16  CPU read data
//  cpu_ok       out  1   cpu_data valid for current cpu_addr
//  gfx_req/gfx_addr/gfx_data/gfx_ok  same as cpu_*
//  mem_addr     out  MW  memory word address
//  mem_din      out  16  write data
//  mem_be       out  2   byte enables; [0] low byte = even ioctl address
//  mem_we       out  1   write request, held until mem_ack
//  mem_rd       out  1   read request, held until mem_ack
//  mem_dout     in   16  read data, valid with mem_ack
//  mem_ack      in   1   one-cycle completion pulse
//  dl_ovf       out  1   sticky: word completed while previous write pending
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; rr pointer=CPU; pack/pending buffers empty.
//  Packing: ioctl_wr with addr[0]=0 stores low byte, sets half flag. With addr[0]=1 and
//   word address matching the stored byte: pending word formed, be=2'b11.
//   Odd byte with no matching half: be=2'b10. New even byte while half set: flush old as
//   be=2'b01 first. Falling edge of downloading with half set: flush be=2'b01.
//  Pending buffer holds one word. Pending occupied when a new word forms -> dl_ovf=1
//   (sticky until rst); new word dropped.
//  FSM states: IDLE, WR, RD.
//   IDLE: pending set -> WR, at most one cycle after word forms.
//    Else if !downloading: pick requester with req & !ok; if both, rr pointer wins -> RD.
//   WR: mem_we=1, mem_addr/mem_din/mem_be from pending. mem_ack -> clear pending, IDLE.
//   RD: mem_rd=1, mem_addr = granted addr + offset. On mem_ack: capture mem_dout into that
//    requester's data; latch its served addr; set its ok; toggle rr pointer; IDLE.
//  Writes have absolute priority over reads; reads never start while downloading=1.
//   An RD already in flight when downloading rises completes normally.
//  ok semantics: xx_ok=1 only while xx_req=1 and xx_addr==served addr. Clears combinationally
//   next cycle after an addr change or req drop. A data latch is never overwritten
//   except by its own grant.
//  Addr change during own RD: the RD completes and data is latched against the old
//   address; ok stays 0; requester re-arbitrates.
//  Minimum read latency: 1 cycle IDLE + mem latency + 1 cycle registered ok.
//  downloading rising edge clears both served-addr valid bits; no stale ok after reload.
//  rst mid-operation: mem_we/mem_rd drop asynchronously; pending and half data discarded.
//  Address arithmetic: mem_addr = addr + offset modulo 2^MW; wraps silently.
// STRUCTURE
//  jtpopeye_pkg: typedef enum {IDLE,WR,RD} arb_st_t; requester index constants REQ_CPU/REQ_GFX.
//  Sub-module jtpopeye_dl_pack: ioctl byte packing, flush, pending buffer, dl_ovf.
//   Its output is pend_valid/pend_addr/pend_data/pend_be with pend_clr input.
//  Top holds FSM, round-robin, per-requester slots. Implement slots as a 2-entry array
//   indexed by REQ_*; this avoids duplicated code.
// TESTING
//  Model: memory with mem_ack 3 cycles after req; scoreboard of expected array contents.
//  1 Download 0x00..0x0F bytes 0xA0+i, ioctl_wr every 8 clk -> 8 writes, be=11,
//    word 0 = 0xA1A0, dl_ovf=0.
//  2 Download ending at odd count (addr 0..4) -> third write addr 2, be=01, data[7:0]=0xA4.
//  3 ioctl_wr every cycle with mem_ack latency 10 -> dl_ovf=1 and stays 1 until rst.
//  4 cpu_req & gfx_req together at addrs 0x10/0x20 -> CPU served first (reset rr);
//    then GFX; both ok=1 with scoreboard data. Repeat -> no new mem_rd (ok held).
//  5 cpu_addr changes while RD pending -> cpu_ok stays 0, second RD issued; correct data for new addr.
//  6 Assert rst during WR -> mem_we=0 same cycle; outputs 0. Raise downloading with req held
//    -> no mem_rd until downloading falls.

Source files
------------

// File: rtl/jtpopeye_pkg.sv
// Shared types and constants for the Popeye ROM memory arbiter.
package jtpopeye_pkg;

    // Arbiter states: idle, download write in flight, game read in flight
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2
    } arb_st_t;

    // Requester slot indices
    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_GFX = 1'b1;
    localparam int   NREQ    = 2;

    // Place a download byte into its lane of a 16-bit word (odd address -> high byte)
    function automatic logic [15:0] place_byte(input logic odd, input logic [7:0] b);
        return odd ? {b, 8'h00} : {8'h00, b};
    endfunction

endpackage

// File: rtl/jtpopeye_dl_pack.sv
// Packs ioctl download bytes into 16-bit words with byte enables and holds
// one completed word until the arbiter writes it. A word completing while
// the previous one is still pending is dropped and flagged in o_dl_ovf.
module jtpopeye_dl_pack
    import jtpopeye_pkg::*;
#(
    parameter int MW = 15
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_downloading,
    input  logic [21:0]   i_ioctl_addr,
    input  logic [7:0]    i_ioctl_data,
    input  logic          i_ioctl_wr,
    input  logic          i_pend_clr,
    output logic          o_pend_valid,
    output logic [MW-1:0] o_pend_addr,
    output logic [15:0]   o_pend_data,
    output logic [1:0]    o_pend_be,
    output logic          o_dl_ovf
);

    logic          r_half;
    logic [MW-1:0] r_half_addr;
    logic [7:0]    r_half_byte;
    logic          r_dl_q;
    logic          r_pend_valid;
    logic [MW-1:0] r_pend_addr;
    logic [15:0]   r_pend_data;
    logic [1:0]    r_pend_be;
    logic          r_ovf;

    logic          w_odd;
    logic [MW-1:0] w_waddr;
    logic          w_dl_fall;
    logic          w_match;
    logic          w_form;
    logic [MW-1:0] w_form_addr;
    logic [15:0]   w_form_data;
    logic [1:0]    w_form_be;
    logic          w_slot_busy;
    logic          w_unused_addr;

    assign w_odd         = i_ioctl_addr[0];
    assign w_waddr       = i_ioctl_addr[MW:1];
    assign w_unused_addr = ^i_ioctl_addr[21:MW+1];
    assign w_dl_fall     = r_dl_q & ~i_downloading;
    assign w_match       = r_half && (r_half_addr == w_waddr);
    // The slot frees in the same cycle the arbiter retires it
    assign w_slot_busy   = r_pend_valid & ~i_pend_clr;

    // Decide whether a word completes this cycle and what it contains
    always_comb begin
        w_form      = 1'b0;
        w_form_addr = w_waddr;
        w_form_data = 16'h0000;
        w_form_be   = 2'b00;
        if (i_ioctl_wr) begin
            if (!w_odd) begin
                // A new even byte pushes out an unpaired low byte
                if (r_half) begin
                    w_form      = 1'b1;
                    w_form_addr = r_half_addr;
                    w_form_data = place_byte(1'b0, r_half_byte);
                    w_form_be   = 2'b01;
                end
            end else if (w_match) begin
                w_form      = 1'b1;
                w_form_data = {i_ioctl_data, r_half_byte};
                w_form_be   = 2'b11;
            end else begin
                w_form      = 1'b1;
                w_form_data = place_byte(1'b1, i_ioctl_data);
                w_form_be   = 2'b10;
            end
        end else if (w_dl_fall && r_half) begin
            w_form      = 1'b1;
            w_form_addr = r_half_addr;
            w_form_data = place_byte(1'b0, r_half_byte);
            w_form_be   = 2'b01;
        end
    end

    // Half-word buffer for the low byte awaiting its partner
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_half      <= 1'b0;
            r_half_addr <= '0;
            r_half_byte <= 8'h00;
            r_dl_q      <= 1'b0;
        end else begin
            r_dl_q <= i_downloading;
            if (i_ioctl_wr) begin
                if (!w_odd) begin
                    r_half      <= 1'b1;
                    r_half_addr <= w_waddr;
                    r_half_byte <= i_ioctl_data;
                end else if (w_match) begin
                    r_half <= 1'b0;
                end
            end else if (w_dl_fall) begin
                r_half <= 1'b0;
            end
        end
    end

    // Single-entry pending word buffer and sticky overflow flag
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pend_valid <= 1'b0;
            r_pend_addr  <= '0;
            r_pend_data  <= 16'h0000;
            r_pend_be    <= 2'b00;
            r_ovf        <= 1'b0;
        end else begin
            if (i_pend_clr) r_pend_valid <= 1'b0;
            if (w_form) begin
                if (w_slot_busy) begin
                    r_ovf <= 1'b1;
                end else begin
                    r_pend_valid <= 1'b1;
                    r_pend_addr  <= w_form_addr;
                    r_pend_data  <= w_form_data;
                    r_pend_be    <= w_form_be;
                end
            end
        end
    end

    assign o_pend_valid = r_pend_valid;
    assign o_pend_addr  = r_pend_addr;
    assign o_pend_data  = r_pend_data;
    assign o_pend_be    = r_pend_be;
    assign o_dl_ovf     = r_ovf;

endmodule

// File: rtl/jtpopeye_mem_arb.sv
// Shares one 16-bit ROM port between download writes and two game readers
// (CPU, graphics). Writes always win; reads are round-robin and only start
// while no download is running. Each reader owns a slot holding its last
// data and the address it was served for; ok is valid only while the reader
// still asks for that same address.
// Memory handshake: o_mem_we/o_mem_rd rise with address/data stable and stay
// high, unchanged, until the single-cycle i_mem_ack; they drop on the next edge.
module jtpopeye_mem_arb
    import jtpopeye_pkg::*;
#(
    parameter int            MW      = 15,
    parameter logic [MW-1:0] CPU_OFS = '0,
    parameter logic [MW-1:0] GFX_OFS = '0
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_downloading,
    input  logic [21:0]   i_ioctl_addr,
    input  logic [7:0]    i_ioctl_data,
    input  logic          i_ioctl_wr,
    input  logic          i_cpu_req,
    input  logic [MW-1:0] i_cpu_addr,
    output logic [15:0]   o_cpu_data,
    output logic          o_cpu_ok,
    input  logic          i_gfx_req,
    input  logic [MW-1:0] i_gfx_addr,
    output logic [15:0]   o_gfx_data,
    output logic          o_gfx_ok,
    output logic [MW-1:0] o_mem_addr,
    output logic [15:0]   o_mem_din,
    output logic [1:0]    o_mem_be,
    output logic          o_mem_we,
    output logic          o_mem_rd,
    input  logic [15:0]   i_mem_dout,
    input  logic          i_mem_ack,
    output logic          o_dl_ovf,
    output arb_st_t       o_dbg_st
);

    arb_st_t       r_st;
    logic          r_we;
    logic          r_rd;
    logic [MW-1:0] r_mem_addr;
    logic [15:0]   r_mem_din;
    logic [1:0]    r_mem_be;
    logic          r_rr;
    logic          r_gnt;
    logic [MW-1:0] r_rd_addr;
    logic          r_dl_q;
    logic [15:0]   r_data     [NREQ];
    logic [MW-1:0] r_srv_addr [NREQ];
    logic          r_srv_vld  [NREQ];

    logic          w_req  [NREQ];
    logic [MW-1:0] w_addr [NREQ];
    logic [MW-1:0] w_ofs  [NREQ];
    logic          w_ok   [NREQ];
    logic          w_need [NREQ];
    logic          w_gnt_any;
    logic          w_gnt;
    logic          w_dl_rise;
    logic          w_pend_valid;
    logic [MW-1:0] w_pend_addr;
    logic [15:0]   w_pend_data;
    logic [1:0]    w_pend_be;
    logic          w_pend_clr;

    assign w_req[REQ_CPU]  = i_cpu_req;
    assign w_req[REQ_GFX]  = i_gfx_req;
    assign w_addr[REQ_CPU] = i_cpu_addr;
    assign w_addr[REQ_GFX] = i_gfx_addr;
    assign w_ofs[REQ_CPU]  = CPU_OFS;
    assign w_ofs[REQ_GFX]  = GFX_OFS;
    assign w_dl_rise       = i_downloading & ~r_dl_q;
    assign w_pend_clr      = (r_st == WR) && i_mem_ack;

    jtpopeye_dl_pack #(.MW(MW)) u_pack (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_downloading (i_downloading),
        .i_ioctl_addr  (i_ioctl_addr),
        .i_ioctl_data  (i_ioctl_data),
        .i_ioctl_wr    (i_ioctl_wr),
        .i_pend_clr    (w_pend_clr),
        .o_pend_valid  (w_pend_valid),
        .o_pend_addr   (w_pend_addr),
        .o_pend_data   (w_pend_data),
        .o_pend_be     (w_pend_be),
        .o_dl_ovf      (o_dl_ovf)
    );

    // Per-requester ok and outstanding need
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            w_ok[i]   = r_srv_vld[i] && w_req[i] && (w_addr[i] == r_srv_addr[i]);
            w_need[i] = w_req[i] && !w_ok[i];
        end
    end

    // Round-robin pick; the pointer only matters when both need service
    always_comb begin
        w_gnt_any = w_need[REQ_CPU] || w_need[REQ_GFX];
        if (w_need[REQ_CPU] && w_need[REQ_GFX]) w_gnt = r_rr;
        else if (w_need[REQ_GFX])               w_gnt = REQ_GFX;
        else                                    w_gnt = REQ_CPU;
    end

    // Arbiter FSM, memory request registers and requester slots
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_st       <= IDLE;
            r_we       <= 1'b0;
            r_rd       <= 1'b0;
            r_mem_addr <= '0;
            r_mem_din  <= 16'h0000;
            r_mem_be   <= 2'b00;
            r_rr       <= REQ_CPU;
            r_gnt      <= REQ_CPU;
            r_rd_addr  <= '0;
            r_dl_q     <= 1'b0;
            for (int i = 0; i < NREQ; i++) begin
                r_data[i]     <= 16'h0000;
                r_srv_addr[i] <= '0;
                r_srv_vld[i]  <= 1'b0;
            end
        end else begin
            r_dl_q <= i_downloading;
            // New ROM contents invalidate everything served before
            if (w_dl_rise) begin
                for (int i = 0; i < NREQ; i++) r_srv_vld[i] <= 1'b0;
            end
            case (r_st)
                IDLE: begin
                    if (w_pend_valid) begin
                        r_st       <= WR;
                        r_we       <= 1'b1;
                        r_mem_addr <= w_pend_addr;
                        r_mem_din  <= w_pend_data;
                        r_mem_be   <= w_pend_be;
                    end else if (!i_downloading && w_gnt_any) begin
                        r_st       <= RD;
                        r_rd       <= 1'b1;
                        r_gnt      <= w_gnt;
                        r_rd_addr  <= w_addr[w_gnt];
                        r_mem_addr <= w_addr[w_gnt] + w_ofs[w_gnt];
                        r_mem_be   <= 2'b11;
                    end
                end
                WR: begin
                    if (i_mem_ack) begin
                        r_we <= 1'b0;
                        r_st <= IDLE;
                    end
                end
                RD: begin
                    if (i_mem_ack) begin
                        r_rd              <= 1'b0;
                        r_data[r_gnt]     <= i_mem_dout;
                        r_srv_addr[r_gnt] <= r_rd_addr;
                        r_srv_vld[r_gnt]  <= 1'b1;
                        r_rr              <= ~r_rr;
                        r_st              <= IDLE;
                    end
                end
                default: r_st <= IDLE;
            endcase
        end
    end

    assign o_mem_we   = r_we;
    assign o_mem_rd   = r_rd;
    assign o_mem_addr = r_mem_addr;
    assign o_mem_din  = r_mem_din;
    assign o_mem_be   = r_mem_be;
    assign o_cpu_data = r_data[REQ_CPU];
    assign o_gfx_data = r_data[REQ_GFX];
    assign o_cpu_ok   = w_ok[REQ_CPU];
    assign o_gfx_ok   = w_ok[REQ_GFX];
    assign o_dbg_st   = r_st;

endmodule

// File: tb/tb_jtpopeye_mem_arb.sv
// Directed bench for jtpopeye_mem_arb with a small acknowledging memory model.
module tb_jtpopeye_mem_arb;
    import jtpopeye_pkg::*;

    localparam int MW = 15;

    typedef struct {
        logic [MW-1:0] addr;
        logic [15:0]   data;
        logic [1:0]    be;
    } wr_vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          downloading = 1'b0;
    logic [21:0]   ioctl_addr = '0;
    logic [7:0]    ioctl_data = '0;
    logic          ioctl_wr = 1'b0;
    logic          cpu_req = 1'b0;
    logic [MW-1:0] cpu_addr = '0;
    logic [15:0]   cpu_data;
    logic          cpu_ok;
    logic          gfx_req = 1'b0;
    logic [MW-1:0] gfx_addr = '0;
    logic [15:0]   gfx_data;
    logic          gfx_ok;
    logic [MW-1:0] mem_addr;
    logic [15:0]   mem_din;
    logic [1:0]    mem_be;
    logic          mem_we;
    logic          mem_rd;
    logic [15:0]   mem_dout = '0;
    logic          mem_ack = 1'b0;
    logic          dl_ovf;
    arb_st_t       dbg_st;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- clock / reset ----------------
    always #12 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "bench did not finish in time");
    end

    jtpopeye_mem_arb #(.MW(MW)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_downloading (downloading),
        .i_ioctl_addr  (ioctl_addr),
        .i_ioctl_data  (ioctl_data),
        .i_ioctl_wr    (ioctl_wr),
        .i_cpu_req     (cpu_req),
        .i_cpu_addr    (cpu_addr),
        .o_cpu_data    (cpu_data),
        .o_cpu_ok      (cpu_ok),
        .i_gfx_req     (gfx_req),
        .i_gfx_addr    (gfx_addr),
        .o_gfx_data    (gfx_data),
        .o_gfx_ok      (gfx_ok),
        .o_mem_addr    (mem_addr),
        .o_mem_din     (mem_din),
        .o_mem_be      (mem_be),
        .o_mem_we      (mem_we),
        .o_mem_rd      (mem_rd),
        .i_mem_dout    (mem_dout),
        .i_mem_ack     (mem_ack),
        .o_dl_ovf      (dl_ovf),
        .o_dbg_st      (dbg_st)
    );

    // ---------------- memory model ----------------
    logic [15:0]   mem_arr [0:511];
    int            mem_lat = 3;
    logic          busy = 1'b0;
    int            cnt = 0;
    wr_vec_t       obs_wr_q[$];
    logic [MW-1:0] obs_rd_q[$];

    function automatic logic [15:0] rd_pat(input logic [MW-1:0] a);
        return 16'h5000 ^ {7'd0, a[8:0]};
    endfunction

    initial begin
        for (int i = 0; i < 512; i++) mem_arr[i] = 16'h5000 ^ 16'(i);
    end

    always @(posedge clk) begin
        if (rst) begin
            busy    <= 1'b0;
            cnt     <= 0;
            mem_ack <= 1'b0;
        end else begin
            mem_ack <= 1'b0;
            if (busy) begin
                if (cnt >= mem_lat) begin
                    mem_ack <= 1'b1;
                    busy    <= 1'b0;
                    if (mem_we) begin
                        if (mem_be[0]) mem_arr[mem_addr[8:0]][7:0]  <= mem_din[7:0];
                        if (mem_be[1]) mem_arr[mem_addr[8:0]][15:8] <= mem_din[15:8];
                        obs_wr_q.push_back('{addr: mem_addr, data: mem_din, be: mem_be});
                    end else begin
                        mem_dout <= mem_arr[mem_addr[8:0]];
                    end
                end else begin
                    cnt <= cnt + 1;
                end
            end else if ((mem_we || mem_rd) && !mem_ack) begin
                busy <= 1'b1;
                cnt  <= 1;
                if (mem_rd) obs_rd_q.push_back(mem_addr);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input int a, input logic [7:0] d, input int gap);
        ioctl_addr = 22'(a);
        ioctl_data = d;
        ioctl_wr   = 1'b1;
        tick();
        ioctl_wr   = 1'b0;
        repeat (gap - 1) tick();
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    wr_vec_t       wr_tab[11];
    logic [15:0]   exp_q[$];

    task automatic check_writes(input int first, input int num);
        wr_vec_t      o;
        logic [15:0]  m;
        check("wr_count", 32'(obs_wr_q.size()), 32'(num));
        for (int k = first; k < first + num; k++) begin
            if (obs_wr_q.size() != 0) begin
                o = obs_wr_q.pop_front();
                m = {{8{wr_tab[k].be[1]}}, {8{wr_tab[k].be[0]}}};
                check($sformatf("wr%0d_addr", k), 32'(o.addr), 32'(wr_tab[k].addr));
                check($sformatf("wr%0d_be", k), 32'(o.be), 32'(wr_tab[k].be));
                check($sformatf("wr%0d_data", k), 32'(o.data & m), 32'(wr_tab[k].data & m));
            end
        end
        obs_wr_q.delete();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int n;
        bit got;

        for (int i = 0; i < 8; i++)
            wr_tab[i] = '{addr: MW'(i), data: {8'(8'hA1 + 2*i), 8'(8'hA0 + 2*i)}, be: 2'b11};
        wr_tab[8]  = '{addr: MW'(0), data: 16'hA1A0, be: 2'b11};
        wr_tab[9]  = '{addr: MW'(1), data: 16'hA3A2, be: 2'b11};
        wr_tab[10] = '{addr: MW'(2), data: 16'h00A4, be: 2'b01};

        // Reset state
        repeat (3) tick();
        check("rst_mem_we", 32'(mem_we), 0);
        check("rst_mem_rd", 32'(mem_rd), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_mem_be_din", {14'd0, mem_be, mem_din}, 0);
        check("rst_oks", {30'd0, cpu_ok, gfx_ok}, 0);
        check("rst_dl_ovf", 32'(dl_ovf), 0);
        check("rst_state", 32'(dbg_st), 32'(IDLE));
        rst = 1'b0;
        tick();

        // 1: full-word download, one byte every 8 clocks
        downloading = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) send_byte(i, 8'(8'hA0 + i), 8);
        repeat (20) tick();
        downloading = 1'b0;
        repeat (4) tick();
        check_writes(0, 8);
        check("t1_dl_ovf", 32'(dl_ovf), 0);

        // 2: odd byte count, trailing low byte flushed on download end
        downloading = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) send_byte(i, 8'(8'hA0 + i), 8);
        repeat (20) tick();
        downloading = 1'b0;
        repeat (10) tick();
        check_writes(8, 3);

        // 3: back-to-back bytes against slow memory overflow the pending slot
        mem_lat = 10;
        downloading = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) send_byte(i, 8'(i), 1);
        check("t3_ovf_set", 32'(dl_ovf), 1);
        downloading = 1'b0;
        repeat (40) tick();
        check("t3_ovf_sticky", 32'(dl_ovf), 1);
        rst = 1'b1;
        tick();
        check("t3_ovf_rst", 32'(dl_ovf), 0);
        rst = 1'b0;
        mem_lat = 3;
        tick();
        obs_wr_q.delete();
        obs_rd_q.delete();

        // 4: simultaneous requests, CPU first after reset
        cpu_addr = MW'(16'h10);
        gfx_addr = MW'(16'h20);
        cpu_req = 1'b1;
        gfx_req = 1'b1;
        exp_q.push_back(rd_pat(MW'(16'h10)));
        exp_q.push_back(rd_pat(MW'(16'h20)));
        got = 1'b0;
        for (int c = 0; c < 60 && !got; c++) begin
            tick();
            got = cpu_ok && gfx_ok;
        end
        check("t4_both_ok", 32'(got), 1);
        check("t4_rd_count", 32'(obs_rd_q.size()), 2);
        if (obs_rd_q.size() == 2) begin
            check("t4_first_addr", 32'(obs_rd_q[0]), 32'h10);
            check("t4_second_addr", 32'(obs_rd_q[1]), 32'h20);
        end
        check("t4_cpu_data", 32'(cpu_data), 32'(exp_q.pop_front()));
        check("t4_gfx_data", 32'(gfx_data), 32'(exp_q.pop_front()));
        obs_rd_q.delete();
        repeat (20) tick();
        check("t4_hold_no_rd", 32'(obs_rd_q.size()), 0);
        cpu_req = 1'b0;
        gfx_req = 1'b0;
        tick();
        check("t4_ok_drop", {30'd0, cpu_ok, gfx_ok}, 0);
        cpu_req = 1'b1;
        gfx_req = 1'b1;
        tick();
        check("t4_ok_back", {30'd0, cpu_ok, gfx_ok}, 3);
        repeat (10) tick();
        check("t4_reissue_no_rd", 32'(obs_rd_q.size()), 0);

        // 5: CPU address changes while its read is in flight
        gfx_req = 1'b0;
        cpu_addr = MW'(16'h30);
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            tick();
            got = mem_rd;
        end
        check("t5_rd_start", 32'(got), 1);
        cpu_addr = MW'(16'h31);
        got = 1'b0;
        for (int c = 0; c < 60 && !got; c++) begin
            tick();
            got = cpu_ok;
            if (got) check("t5_two_reads_before_ok", 32'(obs_rd_q.size()), 2);
        end
        check("t5_ok", 32'(got), 1);
        if (obs_rd_q.size() == 2) check("t5_second_addr", 32'(obs_rd_q[1]), 32'h31);
        check("t5_cpu_data", 32'(cpu_data), 32'(rd_pat(MW'(16'h31))));
        obs_rd_q.delete();

        // 6a: download start drops ok and blocks reads until it ends
        downloading = 1'b1;
        tick();
        check("t6_ok_cleared", 32'(cpu_ok), 0);
        n = 0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (mem_rd) n++;
        end
        check("t6_no_rd_dl", 32'(n), 0);
        downloading = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            tick();
            got = cpu_ok;
        end
        check("t6_ok_after_dl", 32'(got), 1);
        check("t6_rd_count", 32'(obs_rd_q.size()), 1);
        check("t6_cpu_data", 32'(cpu_data), 32'(rd_pat(MW'(16'h31))));
        cpu_req = 1'b0;
        obs_rd_q.delete();

        // 6b: asynchronous reset during a write
        downloading = 1'b1;
        tick();
        send_byte(16'h40, 8'h11, 1);
        send_byte(16'h41, 8'h22, 1);
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            got = mem_we;
            if (!got) tick();
        end
        check("t6_we_seen", 32'(got), 1);
        #3;
        rst = 1'b1;
        #1;
        check("t6_rst_we", 32'(mem_we), 0);
        check("t6_rst_rd_be", {29'd0, mem_rd, mem_be}, 0);
        check("t6_rst_addr", 32'(mem_addr), 0);
        check("t6_rst_state", 32'(dbg_st), 32'(IDLE));
        tick();
        tick();
        rst = 1'b0;
        downloading = 1'b0;
        repeat (12) tick();
        check("t6_pend_dropped", {31'd0, mem_we}, 0);
        check("t6_no_write", 32'(obs_wr_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
